// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO arbiter slice.
//   NUM_Q      : number of input FIFOs (fixed at 4)
//   PTR_W      : width of the round-robin pointer / grant index
//   ST_*       : one-hot FSM state encodings (bit0 RESET .. bit3 ACTIVE)
//   onehot_idx : converts a one-hot grant vector into its index
package fifo_arb_pkg;

  localparam int NUM_Q = 4;
  localparam int PTR_W = 2;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_Q-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      if (oh[k]) idx = PTR_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter choosing one input FIFO to pop.
// Configuration macro: FIFO_ARB_STRICT_PRIO_EN
//   undefined : round-robin, first requester cyclically after ptr wins
//   defined   : strict priority, lowest-index requester wins, ptr ignored
// Ports:
//   req [NUM_Q-1:0] in  : request per FIFO (FIFO non-empty)
//   ptr [PTR_W-1:0] in  : index granted most recently
//   en              in  : arbitration enable; gnt is zero when low
//   gnt [NUM_Q-1:0] out : one-hot grant (or zero)
module rr_arbiter
  import fifo_arb_pkg::*;
(
  input  logic [NUM_Q-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [NUM_Q-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

`ifdef FIFO_ARB_STRICT_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int k = 0; k < NUM_Q; k++) begin
        idx = PTR_W'(k);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  // Scan ptr+1, ptr+2, ... ptr+NUM_Q; the pointer-width add wraps 3 -> 0.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int k = 1; k <= NUM_Q; k++) begin
        idx = ptr + PTR_W'(k);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_arbiter.sv
// Arbitrates NUM_Q input FIFOs into one downstream FIFO and broadcasts
// programmable almost-full / almost-empty thresholds.
// Configuration macro: FIFO_ARB_STRICT_PRIO_EN (strict priority instead of
// round-robin, selected inside rr_arbiter).
// Ports:
//   clk, reset (sync, active-high), init (threshold reload pulse)
//   umb_almost_full_in / umb_almost_empty_in : thresholds to load in INIT
//   fifo_empty [NUM_Q], fifo_data [NUM_Q*DATA_SIZE] : input FIFO status/data
//   out_almost_full : downstream back-pressure
//   pop [NUM_Q] : one-hot read strobe;  push / data_out : downstream write
//   umb_almost_full / umb_almost_empty : latched thresholds
//   grant : index popped most recently;  state : one-hot FSM state
//   idle  : IDLE with every input FIFO empty and no push in flight
module fifo_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_SIZE  = 3,
  parameter int NUM_Q     = fifo_arb_pkg::NUM_Q
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [CNT_SIZE-1:0]        umb_almost_full_in,
  input  logic [CNT_SIZE-1:0]        umb_almost_empty_in,
  input  logic [NUM_Q-1:0]           fifo_empty,
  input  logic [NUM_Q*DATA_SIZE-1:0] fifo_data,
  input  logic                       out_almost_full,
  output logic [NUM_Q-1:0]           pop,
  output logic                       push,
  output logic [DATA_SIZE-1:0]       data_out,
  output logic [CNT_SIZE-1:0]        umb_almost_full,
  output logic [CNT_SIZE-1:0]        umb_almost_empty,
  output logic [1:0]                 grant,
  output logic [3:0]                 state,
  output logic                       idle
);
  import fifo_arb_pkg::*;

  logic [3:0]           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 push_q;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [CNT_SIZE-1:0]  af_q, af_d, ae_q, ae_d;

  logic [NUM_Q-1:0]     req;
  logic [NUM_Q-1:0]     gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 any_req;
  logic                 arb_en;
  logic                 popping;

  assign req     = ~fifo_empty;
  assign any_req = |req;
  // Reset gates the strobe combinationally so nothing is popped while held.
  assign arb_en  = (state_q == ST_ACTIVE) && !out_almost_full && !reset;

  rr_arbiter u_arb (
    .req (req),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign gnt_idx = onehot_idx(gnt);
  assign popping = |gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)                             state_d = ST_INIT;
        else if (any_req && !out_almost_full) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                             state_d = ST_INIT;
        else if (!any_req || out_almost_full) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  always_comb begin
    ptr_d  = popping ? gnt_idx : ptr_q;
    data_d = popping ? fifo_data[int'(gnt_idx)*DATA_SIZE +: DATA_SIZE] : data_q;
    af_d   = (state_q == ST_INIT) ? umb_almost_full_in  : af_q;
    ae_d   = (state_q == ST_INIT) ? umb_almost_empty_in : ae_q;
  end

  // Pointer resets to the last index so FIFO 0 is served first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      ptr_q   <= '1;
      push_q  <= 1'b0;
      data_q  <= '0;
      af_q    <= '0;
      ae_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      push_q  <= popping;
      data_q  <= data_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  end

  assign pop              = gnt;
  assign push             = push_q;
  assign data_out         = data_q;
  assign umb_almost_full  = af_q;
  assign umb_almost_empty = ae_q;
  assign grant            = ptr_q;
  assign state            = state_q;
  assign idle             = (state_q == ST_IDLE) && (&fifo_empty) && !push_q;

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 6, width of one data word.
REQ-002 SHALL have parameter CNT_SIZE, default 3, width of the FIFO threshold values.
REQ-003 SHALL have parameter NUM_Q, fixed at 4, number of input FIFOs.
REQ-004 SHALL have port clk  input  1  single clock; all logic is updated on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port init  input  1  one-cycle pulse requesting a threshold reload.
REQ-007 SHALL have port umb_almost_full_in  input  CNT_SIZE  almost-full threshold to load.
REQ-008 SHALL have port umb_almost_empty_in  input  CNT_SIZE  almost-empty threshold to load.
REQ-009 SHALL have port fifo_empty  input  NUM_Q  empty flags of the input FIFOs; bit i belongs to FIFO i.
REQ-010 SHALL have port fifo_data  input  NUM_Q*DATA_SIZE  input FIFO read data; slice i belongs to FIFO i.
REQ-011 SHALL have port out_almost_full  input  1  almost-full flag of the downstream FIFO.
REQ-012 SHALL have port pop  output  NUM_Q  one-hot read strobe to the input FIFOs.
REQ-013 SHALL have port push  output  1  write strobe to the downstream FIFO.
REQ-014 SHALL have port data_out  output  DATA_SIZE  write data to the downstream FIFO.
REQ-015 SHALL have port umb_almost_full  output  CNT_SIZE  latched almost-full threshold, broadcast to all FIFOs.
REQ-016 SHALL have port umb_almost_empty  output  CNT_SIZE  latched almost-empty threshold, broadcast to all FIFOs.
REQ-017 SHALL have port grant  output  2  index of the FIFO popped most recently.
REQ-018 SHALL have port state  output  4  one-hot state: bit0 RESET, bit1 INIT, bit2 IDLE, bit3 ACTIVE.
REQ-019 SHALL have port idle  output  1  high while in IDLE with all fifo_empty bits high and push low.

Function
REQ-020 FSM transitions SHALL be:
- RESET -> INIT on the first cycle with reset low.
- INIT -> IDLE after exactly one cycle.
- IDLE -> ACTIVE when any fifo_empty bit is low and out_almost_full is low.
- ACTIVE -> IDLE when no FIFO is eligible or out_almost_full is high.
- IDLE or ACTIVE -> INIT when init is high.
REQ-021 In INIT, umb_almost_full and umb_almost_empty SHALL capture the _in values; the outputs SHALL hold those values in all other states.
REQ-022 pop SHALL be low in RESET and INIT, and in every cycle where out_almost_full is high or all fifo_empty bits are high.
REQ-023 In ACTIVE, pop SHALL assert exactly one bit per cycle, for the FIFO chosen by round-robin arbitration.
REQ-024 Round-robin SHALL pick the first non-empty FIFO cyclically after the last granted index.
REQ-025 The round-robin pointer SHALL update only on cycles where pop is asserted.
REQ-026 push SHALL equal the previous cycle's OR of pop (one-cycle latency).
REQ-027 data_out SHALL be the fifo_data slice of the FIFO popped in the previous cycle.
REQ-028 A push already in flight SHALL complete even if init, out_almost_full or a state change occurs in the same cycle.
REQ-029 With a single non-empty FIFO, that FIFO SHALL be popped every cycle; no idle gap is inserted.
REQ-030 The pointer SHALL wrap from index 3 to index 0.
REQ-031 If init and reset are both high, reset SHALL win.

Reset
REQ-032 While reset is high, the block SHALL be in RESET with pop=0, push=0, data_out=0, grant=3, both threshold outputs=0 and idle=0.
REQ-033 The round-robin pointer SHALL reset to 3, so that FIFO 0 is served first.
REQ-034 Asserting reset mid-transfer SHALL cancel any pending push on the next edge.

Configuration
REQ-035 With FIFO_ARB_STRICT_PRIO_EN defined, arbitration SHALL be strict priority: the lowest-index non-empty FIFO wins, and the pointer is unused.
REQ-036 Without FIFO_ARB_STRICT_PRIO_EN, arbitration SHALL be round-robin per REQ-024.

Structure
REQ-037 A shared package fifo_arb_pkg SHALL hold the state encoding constants, NUM_Q and the pointer-width constant.
REQ-038 The arbitration logic SHALL be a sub-module rr_arbiter with inputs req[3:0], ptr[1:0] and en, and output gnt[3:0] one-hot.

Verification
REQ-039 Reset 4 cycles, then release with umb_in = 6/3 -> state 0001 -> 0010 -> 0100; thresholds read 6/3; pop stays 0.
REQ-040 All four FIFOs non-empty, out_almost_full=0 -> pop sequence 0001, 0010, 0100, 1000, 0001; push follows one cycle later with matching data_out.
REQ-041 Only FIFO 2 non-empty, holding data 5,6,7 -> pop=0100 for 3 consecutive cycles; data_out 5,6,7 one cycle later; then IDLE and idle=1.
REQ-042 out_almost_full rises while popping -> pop=0 on that cycle; last push still issued; popping resumes at the next round-robin index after the flag drops.
REQ-043 init pulse in ACTIVE with umb_in = 5/2 -> one INIT cycle with pop=0; thresholds become 5/2; state returns to IDLE, then ACTIVE.
REQ-044 Build with FIFO_ARB_STRICT_PRIO_EN, FIFOs 1 and 3 non-empty -> pop=0010 until FIFO 1 is empty, then 1000.
